// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate bus: one-hot bufif1 enables,
// a per-grant hold limit, and an all-off turnaround gap between successive owners.
module tristate_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1,
    localparam int OW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [OW-1:0]    owner,
    output logic             bus_busy,
    output logic             hold_timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              sel_vld;
    logic [OW-1:0]     sel_idx;
    int                idx;

    // Scan downward so the last hit is the one closest to rr_ptr in wrap order.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (req[OW'(idx)]) begin
                sel_vld = 1'b1;
                sel_idx = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    owner_d          = sel_idx;
                    rr_ptr_d         = OW'((int'(sel_idx) + 1) % N_REQ);
                    hold_cnt_d       = '0;
                    state_d          = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[owner_q]) begin
                    grant_d    = '0;
                    turn_cnt_d = '0;
                    state_d    = S_TURN;
                end else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                    grant_d    = '0;
                    turn_cnt_d = '0;
                    timeout_d  = 1'b1;
                    state_d    = S_TURN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_TURN: begin
                grant_d = '0;
                if (turn_cnt_q == TW'(TURN_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Reset drops the bus immediately, skipping the turnaround.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant        = grant_q;
    assign owner        = owner_q;
    assign bus_busy     = busy_q;
    assign hold_timeout = timeout_q;

endmodule
